// File: rtl/mw_load_store_stage.sv
// Memory/writeback stage: captures the execute instruction and runs loads and stores over a
// req/gnt/rvalid port. It formats load data and drives the writeback value, the commit strobe and the upstream stall.
module mw_load_store_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic        flush,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_alu_result,
    input  logic [31:0] ex_store_data,
    input  logic [4:0]  ex_write_address,
    input  logic        ex_reg_write_enable,
    input  logic [1:0]  ex_writeback_select,
    input  logic        ex_mem_read,
    input  logic        ex_mem_write,
    input  logic [2:0]  ex_funct3,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_wstrb,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic        mw_valid,
    output logic [4:0]  mw_write_address,
    output logic        mw_reg_write_enable,
    output logic [1:0]  mw_writeback_select,
    output logic [31:0] mw_writeback_data,
    output logic        mw_commit,
    output logic        mw_misaligned,
    output logic        lsu_stall
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state_q, state_d;

    logic        valid_q;
    logic [31:0] pc_q;
    logic [31:0] alu_q;
    logic [31:0] store_data_q;
    logic [4:0]  rd_q;
    logic        rwe_q;
    logic [1:0]  wbsel_q;
    logic        mem_write_q;
    logic [2:0]  funct3_q;
    logic        misaligned_q;
    logic [31:0] load_data_q, load_data_d;

    logic        capture;
    logic        ex_live;
    logic        ex_mem_op;
    logic        ex_misaligned;

    assign lsu_stall = (state_q == REQ) || (state_q == RESP);
    assign capture   = ~lsu_stall;
    assign ex_live   = ex_valid & ~flush;
    assign ex_mem_op = ex_mem_read | ex_mem_write;

    // Size comes from funct3[1:0]; the reserved encoding 11 is handled like a word.
    always_comb begin
        ex_misaligned = 1'b0;
        case (ex_funct3[1:0])
            2'b00:   ex_misaligned = 1'b0;
            2'b01:   ex_misaligned = ex_alu_result[0];
            default: ex_misaligned = |ex_alu_result[1:0];
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: begin
                if (ex_live && ex_mem_op) begin
                    state_d = ex_misaligned ? DONE : REQ;
                end else begin
                    state_d = IDLE;
                end
            end
            REQ: begin
                if (dmem_gnt) begin
                    state_d = mem_write_q ? DONE : RESP;
                end
            end
            RESP: begin
                if (dmem_rvalid) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            valid_q      <= 1'b0;
            pc_q         <= '0;
            alu_q        <= '0;
            store_data_q <= '0;
            rd_q         <= '0;
            rwe_q        <= 1'b0;
            wbsel_q      <= '0;
            mem_write_q  <= 1'b0;
            funct3_q     <= '0;
            misaligned_q <= 1'b0;
            load_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            load_data_q <= load_data_d;
            if (capture) begin
                valid_q      <= ex_live;
                pc_q         <= ex_pc;
                alu_q        <= ex_alu_result;
                store_data_q <= ex_store_data;
                rd_q         <= ex_write_address;
                rwe_q        <= ex_live & ex_reg_write_enable & ~(ex_mem_op & ex_misaligned);
                wbsel_q      <= ex_writeback_select;
                mem_write_q  <= ex_mem_write;
                funct3_q     <= ex_funct3;
                misaligned_q <= ex_live & ex_mem_op & ex_misaligned;
            end
        end
    end

    // Byte lanes of the store word and of the returned load word.
    logic [7:0] wdata_lane [4];
    logic [7:0] rdata_lane [4];

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        always_comb begin
            wdata_lane[gi] = store_data_q[8*gi +: 8];
            case (funct3_q[1:0])
                2'b00:   wdata_lane[gi] = store_data_q[7:0];
                2'b01:   wdata_lane[gi] = store_data_q[8*(gi%2) +: 8];
                default: wdata_lane[gi] = store_data_q[8*gi +: 8];
            endcase
        end
        assign dmem_wdata[8*gi +: 8] = wdata_lane[gi];
        assign rdata_lane[gi]        = dmem_rdata[8*gi +: 8];
    end

    assign dmem_req  = (state_q == REQ);
    assign dmem_we   = (state_q == REQ) & mem_write_q;
    assign dmem_addr = {alu_q[31:2], 2'b00};

    always_comb begin
        dmem_wstrb = 4'b0000;
        if (dmem_we) begin
            case (funct3_q[1:0])
                2'b00:   dmem_wstrb = 4'b0001 << alu_q[1:0];
                2'b01:   dmem_wstrb = 4'b0011 << alu_q[1:0];
                default: dmem_wstrb = 4'b1111;
            endcase
        end
    end

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [31:0] load_fmt;

    assign sel_byte = rdata_lane[alu_q[1:0]];
    assign sel_half = alu_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

    always_comb begin
        load_fmt = dmem_rdata;
        case (funct3_q)
            3'b000:  load_fmt = {{24{sel_byte[7]}}, sel_byte};
            3'b001:  load_fmt = {{16{sel_half[15]}}, sel_half};
            3'b100:  load_fmt = {24'b0, sel_byte};
            3'b101:  load_fmt = {16'b0, sel_half};
            default: load_fmt = dmem_rdata;
        endcase
    end

    // A response is only taken while waiting for one; stray rvalids are dropped.
    always_comb begin
        load_data_d = load_data_q;
        if ((state_q == RESP) && dmem_rvalid) begin
            load_data_d = load_fmt;
        end
    end

    always_comb begin
        mw_writeback_data = 32'h0;
        case (wbsel_q)
            2'b00:   mw_writeback_data = alu_q;
            2'b01:   mw_writeback_data = pc_q + 32'd4;
            2'b10:   mw_writeback_data = load_data_q;
            default: mw_writeback_data = 32'h0;
        endcase
    end

    assign mw_valid            = valid_q;
    assign mw_write_address    = rd_q;
    assign mw_reg_write_enable = rwe_q;
    assign mw_writeback_select = wbsel_q;
    assign mw_misaligned       = misaligned_q;
    assign mw_commit           = valid_q & ((state_q == IDLE) || (state_q == DONE));

endmodule
